// File: rtl/adc_spi_pkg.sv
// Shared definitions for the ADC SPI responder.
//   DATA_W_DEF / LEAD_ZEROS_DEF : default sample width and leading-zero count
//   FRAME_BITS / BIT_CNT_W      : frame length and bit-counter width for the defaults
//   state_e                     : frame FSM states
package adc_spi_pkg;
    localparam int DATA_W_DEF     = 12;
    localparam int LEAD_ZEROS_DEF = 4;
    localparam int FRAME_BITS     = LEAD_ZEROS_DEF + DATA_W_DEF;
    localparam int BIT_CNT_W      = $clog2(FRAME_BITS + 1);

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_SHIFT   = 2'd1,
        ST_WAIT_CS = 2'd2
    } state_e;
endpackage

// File: rtl/adc_spi_sample_fifo.sv
// Sample FIFO feeding the responder's shift register.
//   clk, rst      : clock and synchronous active-high reset
//   push, wdata   : enqueue request and data (ignored while full)
//   pop, rdata    : dequeue request (ignored while empty); rdata shows the head entry
//   empty         : no entries stored
//   ready         : registered not-full, so a freed slot is offered the cycle after the pop
//   level         : current occupancy
module adc_spi_sample_fifo #(
    parameter int DATA_W = 12,
    parameter int DEPTH  = 8,
    localparam int AW    = $clog2(DEPTH),
    localparam int LW    = $clog2(DEPTH) + 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic [DATA_W-1:0] wdata,
    input  logic              pop,
    output logic [DATA_W-1:0] rdata,
    output logic              empty,
    output logic              ready,
    output logic [LW-1:0]     level
);
    logic [DATA_W-1:0] mem_r [DEPTH];
    logic [AW-1:0]     wr_ptr_r;
    logic [AW-1:0]     rd_ptr_r;
    logic [LW-1:0]     level_r;
    logic [LW-1:0]     level_nxt_s;
    logic              ready_r;
    logic              empty_s;
    logic              push_ok_s;
    logic              pop_ok_s;

    assign empty_s   = (level_r == {LW{1'b0}});
    assign push_ok_s = push & ready_r;
    assign pop_ok_s  = pop & ~empty_s;

    // Next occupancy from the accepted push/pop pair.
    always_comb begin
        level_nxt_s = level_r;
        case ({push_ok_s, pop_ok_s})
            2'b10:   level_nxt_s = level_r + LW'(1);
            2'b01:   level_nxt_s = level_r - LW'(1);
            default: level_nxt_s = level_r;
        endcase
    end

    // Storage write; contents need no reset since level gates every read.
    always_ff @(posedge clk) begin
        if (push_ok_s) begin
            mem_r[wr_ptr_r] <= wdata;
        end
    end

    // Pointers (wrap naturally at DEPTH), occupancy and registered ready.
    always_ff @(posedge clk) begin
        if (rst) begin
            wr_ptr_r <= {AW{1'b0}};
            rd_ptr_r <= {AW{1'b0}};
            level_r  <= {LW{1'b0}};
            ready_r  <= 1'b1;
        end else begin
            if (push_ok_s) begin
                wr_ptr_r <= wr_ptr_r + AW'(1);
            end
            if (pop_ok_s) begin
                rd_ptr_r <= rd_ptr_r + AW'(1);
            end
            level_r <= level_nxt_s;
            ready_r <= (level_nxt_s != LW'(DEPTH));
        end
    end

    assign rdata = mem_r[rd_ptr_r];
    assign empty = empty_s;
    assign ready = ready_r;
    assign level = level_r;
endmodule

// File: rtl/adc_spi_responder.sv
// SPI responder emulating a serial ADC: each CS-low frame shifts out
// LEAD_ZEROS zeros followed by a DATA_W sample, MSB first, changing MISO
// after SCLK falls so the master samples on SCLK rise.
//   CLK50, RESET            : system clock, synchronous active-high reset
//   CS, SCLK                : asynchronous master lines (synchronised here)
//   MISO, MISO_OE           : serial data and pad enable (high while selected)
//   sample_data/valid/ready : host-side sample enqueue port
//   fifo_level              : FIFO occupancy
//   frame_done/frame_abort  : one-cycle pulses on complete / truncated frame end
//   underflow               : one-cycle pulse when a frame starts on an empty FIFO
// Optional build macro ADC_SPI_RAMP_FALLBACK_EN: the fallback sample sent on
// underflow is a ramp counter instead of zero.
module adc_spi_responder
    import adc_spi_pkg::*;
#(
    parameter int DATA_W      = DATA_W_DEF,
    parameter int LEAD_ZEROS  = LEAD_ZEROS_DEF,
    parameter int FIFO_DEPTH  = 8,
    parameter int SYNC_STAGES = 2
) (
    input  logic                         CLK50,
    input  logic                         RESET,
    input  logic                         CS,
    input  logic                         SCLK,
    output logic                         MISO,
    output logic                         MISO_OE,
    input  logic [DATA_W-1:0]            sample_data,
    input  logic                         sample_valid,
    output logic                         sample_ready,
    output logic [$clog2(FIFO_DEPTH):0]  fifo_level,
    output logic                         frame_done,
    output logic                         frame_abort,
    output logic                         underflow
);
    localparam int FRM_BITS = LEAD_ZEROS + DATA_W;
    localparam int CNT_W    = $clog2(FRM_BITS + 1);
    localparam int SETTLE_W = $clog2(SYNC_STAGES + 1);

    logic [SYNC_STAGES-1:0] cs_sync_r;
    logic [SYNC_STAGES-1:0] sclk_sync_r;
    logic                   cs_d_r;
    logic                   sclk_d_r;
    logic [SETTLE_W-1:0]    settle_r;
    logic                   armed_r;
    state_e                 state_r;
    state_e                 state_nxt_s;
    logic [CNT_W-1:0]       bitcnt_r;
    logic [FRM_BITS-1:0]    shreg_r;
    logic                   miso_r;
    logic                   miso_oe_r;
    logic                   frame_done_r;
    logic                   frame_abort_r;
    logic                   underflow_r;
    logic                   cs_s;
    logic                   sclk_s;
    logic                   cs_fall_s;
    logic                   cs_rise_s;
    logic                   sclk_rise_s;
    logic                   sclk_fall_s;
    logic                   settled_s;
    logic                   start_s;
    logic                   abort_s;
    logic                   done_s;
    logic                   fifo_empty_s;
    logic                   fifo_pop_s;
    logic [DATA_W-1:0]      fifo_rdata_s;
    logic [DATA_W-1:0]      fallback_s;
    logic [FRM_BITS-1:0]    frame_word_s;

    adc_spi_sample_fifo #(
        .DATA_W (DATA_W),
        .DEPTH  (FIFO_DEPTH)
    ) u_fifo (
        .clk   (CLK50),
        .rst   (RESET),
        .push  (sample_valid),
        .wdata (sample_data),
        .pop   (fifo_pop_s),
        .rdata (fifo_rdata_s),
        .empty (fifo_empty_s),
        .ready (sample_ready),
        .level (fifo_level)
    );

    assign cs_s        = cs_sync_r[SYNC_STAGES-1];
    assign sclk_s      = sclk_sync_r[SYNC_STAGES-1];
    assign cs_fall_s   = cs_d_r & ~cs_s;
    assign cs_rise_s   = ~cs_d_r & cs_s;
    assign sclk_rise_s = ~sclk_d_r & sclk_s;
    assign sclk_fall_s = sclk_d_r & ~sclk_s;
    // The sync chain still holds reset values until it has been refilled from
    // the pins; arming on those would start a frame if CS was low at reset.
    assign settled_s   = (settle_r == SETTLE_W'(SYNC_STAGES));
    assign fifo_pop_s  = start_s;

`ifdef ADC_SPI_RAMP_FALLBACK_EN
    logic [DATA_W-1:0] ramp_r;

    // Ramp fallback advances once per underflow frame, wrapping naturally.
    always_ff @(posedge CLK50) begin
        if (RESET) begin
            ramp_r <= {DATA_W{1'b0}};
        end else if (start_s && fifo_empty_s) begin
            ramp_r <= ramp_r + DATA_W'(1);
        end else begin
            ramp_r <= ramp_r;
        end
    end

    assign fallback_s = ramp_r;
`else
    assign fallback_s = {DATA_W{1'b0}};
`endif

    assign frame_word_s = {{LEAD_ZEROS{1'b0}}, (fifo_empty_s ? fallback_s : fifo_rdata_s)};

    // Pin synchronisers, edge-detect history, settle counter and armed flag.
    always_ff @(posedge CLK50) begin
        if (RESET) begin
            cs_sync_r   <= {SYNC_STAGES{1'b1}};
            sclk_sync_r <= {SYNC_STAGES{1'b0}};
            cs_d_r      <= 1'b1;
            sclk_d_r    <= 1'b0;
            settle_r    <= {SETTLE_W{1'b0}};
            armed_r     <= 1'b0;
        end else begin
            cs_sync_r   <= {cs_sync_r[SYNC_STAGES-2:0], CS};
            sclk_sync_r <= {sclk_sync_r[SYNC_STAGES-2:0], SCLK};
            cs_d_r      <= cs_s;
            sclk_d_r    <= sclk_s;
            settle_r    <= settled_s ? settle_r : (settle_r + SETTLE_W'(1));
            armed_r     <= armed_r | (settled_s & cs_s);
        end
    end

    // FSM state register.
    always_ff @(posedge CLK50) begin
        if (RESET) begin
            state_r <= ST_IDLE;
        end else begin
            state_r <= state_nxt_s;
        end
    end

    // FSM next state and frame start/end strobes.
    always_comb begin
        state_nxt_s = state_r;
        start_s     = 1'b0;
        abort_s     = 1'b0;
        done_s      = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (cs_fall_s && armed_r) begin
                    start_s     = 1'b1;
                    state_nxt_s = ST_SHIFT;
                end else begin
                    state_nxt_s = ST_IDLE;
                end
            end
            ST_SHIFT: begin
                if (cs_rise_s) begin
                    abort_s     = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else if (sclk_rise_s && (bitcnt_r == CNT_W'(FRM_BITS - 1))) begin
                    state_nxt_s = ST_WAIT_CS;
                end else begin
                    state_nxt_s = ST_SHIFT;
                end
            end
            ST_WAIT_CS: begin
                if (cs_rise_s) begin
                    done_s      = 1'b1;
                    state_nxt_s = ST_IDLE;
                end else begin
                    state_nxt_s = ST_WAIT_CS;
                end
            end
            default: begin
                state_nxt_s = ST_IDLE;
            end
        endcase
    end

    // Shift register, bit counter, MISO and status pulses.
    always_ff @(posedge CLK50) begin
        if (RESET) begin
            shreg_r       <= {FRM_BITS{1'b0}};
            bitcnt_r      <= {CNT_W{1'b0}};
            miso_r        <= 1'b0;
            miso_oe_r     <= 1'b0;
            frame_done_r  <= 1'b0;
            frame_abort_r <= 1'b0;
            underflow_r   <= 1'b0;
        end else begin
            if (start_s) begin
                shreg_r  <= frame_word_s;
                bitcnt_r <= {CNT_W{1'b0}};
            end else if (state_r == ST_SHIFT) begin
                if (sclk_rise_s) begin
                    bitcnt_r <= bitcnt_r + CNT_W'(1);
                end
                if (sclk_fall_s) begin
                    shreg_r <= {shreg_r[FRM_BITS-2:0], 1'b0};
                end
            end

            if (start_s) begin
                miso_r <= frame_word_s[FRM_BITS-1];
            end else if (state_nxt_s != ST_SHIFT) begin
                miso_r <= 1'b0;
            end else if (sclk_fall_s) begin
                miso_r <= shreg_r[FRM_BITS-2];
            end else begin
                miso_r <= miso_r;
            end

            miso_oe_r     <= ~cs_s;
            frame_done_r  <= done_s;
            frame_abort_r <= abort_s;
            underflow_r   <= start_s & fifo_empty_s;
        end
    end

    assign MISO        = miso_r;
    assign MISO_OE     = miso_oe_r;
    assign frame_done  = frame_done_r;
    assign frame_abort = frame_abort_r;
    assign underflow   = underflow_r;
endmodule

// File: tb/tb_adc_spi_responder.sv
// Self-checking bench for adc_spi_responder: the bench plays the SPI master,
// keeps a scoreboard queue of expected frame words and counts status pulses.
module tb_adc_spi_responder;
    logic        CLK50 = 1'b0;
    logic        RESET;
    logic        CS;
    logic        SCLK;
    logic        MISO;
    logic        MISO_OE;
    logic [11:0] sample_data;
    logic        sample_valid;
    logic        sample_ready;
    logic [3:0]  fifo_level;
    logic        frame_done;
    logic        frame_abort;
    logic        underflow;

    int tests = 0;
    int fails = 0;
    int done_cnt = 0;
    int abort_cnt = 0;
    int uf_cnt = 0;
    logic [15:0] sb_q[$];
    logic [11:0] ramp_exp = 12'h000;

    typedef struct {
        logic [11:0] data;
        int          hold;
        logic [3:0]  exp_level;
        logic        exp_ready;
    } push_vec_t;

    push_vec_t pv[9];

    adc_spi_responder dut (
        .CLK50        (CLK50),
        .RESET        (RESET),
        .CS           (CS),
        .SCLK         (SCLK),
        .MISO         (MISO),
        .MISO_OE      (MISO_OE),
        .sample_data  (sample_data),
        .sample_valid (sample_valid),
        .sample_ready (sample_ready),
        .fifo_level   (fifo_level),
        .frame_done   (frame_done),
        .frame_abort  (frame_abort),
        .underflow    (underflow)
    );

    always #10 CLK50 = ~CLK50;

    // Pulse counters, sampled away from the active edge.
    always @(negedge CLK50) begin
        if (frame_done)  done_cnt  <= done_cnt + 1;
        if (frame_abort) abort_cnt <= abort_cnt + 1;
        if (underflow)   uf_cnt    <= uf_cnt + 1;
    end

    initial begin
        #2ms;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    task automatic check(input string nm, input logic [15:0] act, input logic [15:0] exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got 0x%h, expected 0x%h", nm, act, exp);
        end
    endtask

    function automatic logic [15:0] fallback_word();
`ifdef ADC_SPI_RAMP_FALLBACK_EN
        return {4'h0, ramp_exp};
`else
        return 16'h0000;
`endif
    endfunction

    // Push one sample for 'hold' cycles; model accepts while fewer than 8 queued.
    task automatic push_sample(input logic [11:0] d, input int hold);
        sample_valid = 1'b1;
        sample_data  = d;
        for (int h = 0; h < hold; h++) begin
            if (sb_q.size() < 8) sb_q.push_back({4'h0, d});
            @(negedge CLK50);
        end
        sample_valid = 1'b0;
    endtask

    // Master frame of nbits SCLK cycles; optional push in the frame-start cycle.
    task automatic run_frame(input int nbits, input bit do_push, input logic [11:0] pdata,
                             input string nm);
        logic [15:0] exp;
        logic [15:0] rx;
        logic        exp_uf;
        int d0, a0, u0;
        d0 = done_cnt;
        a0 = abort_cnt;
        u0 = uf_cnt;
        if (sb_q.size() == 0) begin
            exp    = fallback_word();
            exp_uf = 1'b1;
`ifdef ADC_SPI_RAMP_FALLBACK_EN
            ramp_exp = ramp_exp + 12'h001;
`endif
        end else begin
            exp    = sb_q.pop_front();
            exp_uf = 1'b0;
        end
        if (do_push) sb_q.push_back({4'h0, pdata});
        rx = 16'h0000;
        CS = 1'b0;
        for (int i = 1; i <= 8; i++) begin
            @(negedge CLK50);
            if (do_push && i == 2) begin
                sample_valid = 1'b1;
                sample_data  = pdata;
            end else if (i == 3) begin
                sample_valid = 1'b0;
            end
        end
        check({nm, "_oe"}, 16'(MISO_OE), 16'h0001);
        for (int b = 0; b < nbits; b++) begin
            SCLK = 1'b1;
            rx = {rx[14:0], MISO};
            repeat (8) @(negedge CLK50);
            SCLK = 1'b0;
            repeat (8) @(negedge CLK50);
        end
        CS = 1'b1;
        repeat (10) @(negedge CLK50);
        check({nm, "_data"}, rx, exp >> (16 - nbits));
        check({nm, "_done"}, 16'(done_cnt - d0), (nbits == 16) ? 16'h0001 : 16'h0000);
        check({nm, "_abort"}, 16'(abort_cnt - a0), (nbits == 16) ? 16'h0000 : 16'h0001);
        check({nm, "_underflow"}, 16'(uf_cnt - u0), {15'h0000, exp_uf});
        check({nm, "_miso_idle"}, 16'(MISO), 16'h0000);
    endtask

    initial begin
        for (int i = 0; i < 8; i++) begin
            pv[i] = '{data: 12'h100 + 12'(i + 1), hold: 1, exp_level: 4'(i + 1),
                      exp_ready: (i < 7)};
        end
        pv[8] = '{data: 12'h999, hold: 3, exp_level: 4'd8, exp_ready: 1'b0};

        RESET = 1'b1;
        CS = 1'b1;
        SCLK = 1'b0;
        sample_valid = 1'b0;
        sample_data = 12'h000;
        repeat (3) @(negedge CLK50);
        RESET = 1'b0;
        @(negedge CLK50);
        check("rst_miso", 16'(MISO), 16'h0000);
        check("rst_oe", 16'(MISO_OE), 16'h0000);
        check("rst_ready", 16'(sample_ready), 16'h0001);
        check("rst_level", 16'(fifo_level), 16'h0000);
        check("rst_pulses", 16'({frame_done, frame_abort, underflow}), 16'h0000);
        repeat (5) @(negedge CLK50);

        // Basic frame.
        push_sample(12'hABC, 1);
        check("abc_level_before", 16'(fifo_level), 16'h0001);
        run_frame(16, 1'b0, 12'h000, "abc");
        check("abc_level_after", 16'(fifo_level), 16'h0000);

        // Fill to full, 9th held sample rejected.
        for (int i = 0; i < 9; i++) begin
            push_sample(pv[i].data, pv[i].hold);
            check($sformatf("fill%0d_level", i), 16'(fifo_level), 16'(pv[i].exp_level));
            check($sformatf("fill%0d_ready", i), 16'(sample_ready), 16'(pv[i].exp_ready));
        end
        for (int f = 0; f < 8; f++) begin
            run_frame(16, 1'b0, 12'h000, $sformatf("order%0d", f));
            if (f == 0) check("ready_after_pop", 16'(sample_ready), 16'h0001);
        end
        check("drained_level", 16'(fifo_level), 16'h0000);

        // Two underflow frames.
        run_frame(16, 1'b0, 12'h000, "uf0");
        run_frame(16, 1'b0, 12'h000, "uf1");

        // Aborted frame drops its sample; next frame carries the following entry.
        push_sample(12'hA5A, 1);
        push_sample(12'h3C3, 1);
        run_frame(7, 1'b0, 12'h000, "abort");
        check("abort_level", 16'(fifo_level), 16'h0001);
        run_frame(16, 1'b0, 12'h000, "post_abort");

        // Reset mid-frame with CS held low.
        push_sample(12'h777, 1);
        CS = 1'b0;
        repeat (8) @(negedge CLK50);
        SCLK = 1'b1;
        repeat (8) @(negedge CLK50);
        SCLK = 1'b0;
        repeat (8) @(negedge CLK50);
        SCLK = 1'b1;
        repeat (4) @(negedge CLK50);
        RESET = 1'b1;
        sb_q.delete();
        ramp_exp = 12'h000;
        repeat (2) @(negedge CLK50);
        check("midrst_miso", 16'(MISO), 16'h0000);
        check("midrst_oe", 16'(MISO_OE), 16'h0000);
        check("midrst_level", 16'(fifo_level), 16'h0000);
        RESET = 1'b0;
        begin
            int u0;
            u0 = uf_cnt;
            for (int k = 0; k < 6; k++) begin
                SCLK = ~SCLK;
                repeat (6) @(negedge CLK50);
            end
            SCLK = 1'b0;
            repeat (4) @(negedge CLK50);
            check("midrst_no_start", 16'(uf_cnt - u0), 16'h0000);
            check("midrst_miso_low", 16'(MISO), 16'h0000);
            check("midrst_oe_follows_cs", 16'(MISO_OE), 16'h0001);
        end
        CS = 1'b1;
        repeat (8) @(negedge CLK50);
        run_frame(16, 1'b0, 12'h000, "after_rst");

        // Push in the same cycle as a frame start on an empty FIFO.
        run_frame(16, 1'b1, 12'h5A5, "same_cycle");
        check("same_cycle_level", 16'(fifo_level), 16'h0001);
        run_frame(16, 1'b0, 12'h000, "pushed_value");
        check("final_level", 16'(fifo_level), 16'h0000);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end
endmodule

// File: doc/adc_spi_responder.md
Name: adc_spi_responder

Overview:
- SPI responder that emulates the serial ADC sitting on the board's CS/SCLK/MISO lines.
- Answers the TOPLEVEL SPI capture master with 16-bit frames: 4 leading zeros, then a 12-bit sample, MSB first.
- Samples come from an internal FIFO loaded by a host-side valid/ready port.
- Used as the far end of the ADC link in loopback builds and system simulation.

Parameters:
- DATA_W, 12, sample width in bits.
- LEAD_ZEROS, 4, zero bits sent before the sample.
- FIFO_DEPTH, 8, sample FIFO entries; must be a power of 2.
- SYNC_STAGES, 2, synchroniser flops on CS and SCLK; minimum 2.

Ports:
- CLK50  in  1  system clock; all logic is on its rising edge.
- RESET  in  1  synchronous, active-high reset.
- CS  in  1  chip select from the master, active low, asynchronous to CLK50.
- SCLK  in  1  serial clock from the master, idles low, asynchronous to CLK50.
- MISO  out  1  serial data to the master.
- MISO_OE  out  1  high while the responder is selected (for tri-state/pad use).
- sample_data  in  DATA_W  sample to enqueue.
- sample_valid  in  1  sample_data is valid.
- sample_ready  out  1  FIFO can accept a sample (not full).
- fifo_level  out  clog2(FIFO_DEPTH)+1  current FIFO occupancy.
- frame_done  out  1  one-cycle pulse: full frame shifted and CS has risen.
- frame_abort  out  1  one-cycle pulse: CS rose before the frame completed.
- underflow  out  1  one-cycle pulse: a frame started with the FIFO empty.

Behaviour:
- Reset values: MISO=0, MISO_OE=0, sample_ready=1, fifo_level=0, all pulse outputs 0.
- Reset empties the FIFO, returns the FSM to IDLE and clears the armed flag.
- Synchronisers: CS flops reset to 1, SCLK flops reset to 0. Edges are detected on the last sync stage only.
- Armed flag:
  - Set whenever the synced CS is high.
  - A frame starts only on a synced CS falling edge while armed.
  - If CS is already low when reset releases, the responder waits for CS high, then the next fall.
- FRAME_BITS = LEAD_ZEROS + DATA_W = 16.
- FSM states: IDLE, SHIFT, WAIT_CS.
  - IDLE, CS fall while armed:
    - Pop the FIFO into shift register {LEAD_ZEROS zeros, sample}.
    - If the FIFO is empty, load the fallback value and pulse underflow.
    - Drive the shift-register MSB on MISO; clear the bit counter; go to SHIFT.
  - SHIFT:
    - Each synced SCLK rising edge increments the bit counter.
    - Each synced SCLK falling edge shifts left one bit; MISO = new MSB.
    - When the counter reaches FRAME_BITS on a rising edge, go to WAIT_CS.
    - A CS rise in SHIFT pulses frame_abort, drops the popped sample (no requeue) and returns to IDLE.
  - WAIT_CS: MISO held 0. On CS rise, pulse frame_done and return to IDLE.
- MISO_OE equals the inverted synced CS. MISO is 0 whenever not in SHIFT.
- Latency: MISO is valid SYNC_STAGES+1 CLK50 cycles after a CS fall, and SYNC_STAGES+1 cycles after an SCLK fall.
- Master timing requirement: SCLK high and low each ≥ SYNC_STAGES+2 CLK50 cycles, and CS fall to first SCLK rise ≥ SYNC_STAGES+2 cycles.
- FIFO rules:
  - Push when sample_valid & sample_ready.
  - A pop and a push in the same cycle are both honoured; fifo_level is unchanged.
  - A push into an empty FIFO in the same cycle as a frame start does not bypass: the frame sees empty and underflow pulses.
  - When full, sample_ready=0 and the push is ignored even if a pop occurs that cycle. sample_ready rises the cycle after the pop.
  - Read and write pointers wrap modulo FIFO_DEPTH.
- SCLK edges outside SHIFT are ignored.

Optional Feature:
- Macro: ADC_SPI_RAMP_FALLBACK_EN.
- Defined:
  - Fallback sample is a DATA_W ramp counter, reset to 0.
  - The counter increments after each underflow frame and wraps from all-ones to 0.
- Undefined: fallback sample is 0.
- underflow pulses in both cases.

Decomposition:
- Shared package adc_spi_pkg:
  - FRAME_BITS.
  - Bit-counter width clog2(FRAME_BITS+1).
  - FSM state enum (IDLE, SHIFT, WAIT_CS).
  - Default DATA_W and LEAD_ZEROS constants.
- One sub-module, adc_spi_sample_fifo: synchronous FIFO with push/pop, full/empty and level outputs.
- Synchronisers, edge detection and the FSM stay in the top block.

Test Plan:
- Push 0xABC, then a CS fall and 16 SCLK cycles (8 CLK50 cycles per half-period), CS rise -> master samples 0000_1010_1011_1100; frame_done pulses once; fifo_level 1->0.
- Push 8 samples with sample_valid held high for a 9th -> sample_ready=0 at level 8; the 9th is not stored. After one frame, sample_ready=1 and the frames carry samples in push order.
- Frame with an empty FIFO -> underflow pulses.
  - Macro defined: data 0x000, then 0x001 on the next underflow frame.
  - Macro undefined: data 0x000 on both frames.
- CS rise after 7 SCLK cycles -> frame_abort pulses, frame_done stays low, the sample is lost, and the next frame carries the following FIFO entry.
- RESET asserted mid-frame with CS held low -> MISO=0, MISO_OE=0, FIFO empty. No frame starts until CS goes high and falls again.
- Push and frame start in the same cycle with the FIFO empty -> underflow pulses and fifo_level=1 afterwards; the next frame returns the pushed value.
